// File: rtl/word_serializer_704_if.sv
// Handshake bundle between the 704-bit FIFO stage, the serializer and the
// 32-bit downstream consumer. The master view belongs to the serializer.
interface word_serializer_704_if #(
  parameter int BEAT_WIDTH = 32,
  parameter int BEATS      = 22
);
  // Upstream FIFO side (out_first / out_deq methods)
  logic [BEAT_WIDTH*BEATS-1:0] in_first;
  logic                        in_first__RDY;
  logic                        in_deq__RDY;
  logic                        in_deq__ENA;
  // Downstream enq side
  logic [BEAT_WIDTH-1:0]       out_enq_v;
  logic                        out_enq__ENA;
  logic                        out_enq__RDY;
  logic                        out_last;

  modport master (
    input  in_first, in_first__RDY, in_deq__RDY, out_enq__RDY,
    output in_deq__ENA, out_enq_v, out_enq__ENA, out_last
  );

  modport slave (
    output in_first, in_first__RDY, in_deq__RDY, out_enq__RDY,
    input  in_deq__ENA, out_enq_v, out_enq__ENA, out_last
  );
endinterface

// File: rtl/word_serializer_704.sv
// Pulls one 704-bit word from the upstream FIFO and emits it as 22 beats of
// 32 bits, least-significant beat first. The next word is dequeued in the
// same cycle as the last beat, so an always-ready consumer sees no bubbles.
module word_serializer_704 (
  input  logic                  CLK,
  input  logic                  RST,
  word_serializer_704_if.master bus,
  output logic [15:0]           words_sent
);
  localparam int        BEAT_WIDTH = 32;
  localparam int        BEATS      = 22;
  localparam logic [4:0] LAST_IDX  = 5'(BEATS - 1);

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_SENDING = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [4:0]                  r_idx;
  logic [15:0]                 r_words_sent;
  logic [BEAT_WIDTH*BEATS-1:0] w_buf_flat;
  logic                        w_valid;
  logic                        w_at_last;
  logic                        w_fire;
  logic                        w_load_ok;
  logic                        w_load;

  assign w_valid   = (r_state == ST_SENDING);
  assign w_at_last = (r_idx == LAST_IDX);

  // Next-state and handshake strobes; strobes are gated by reset so nothing
  // transfers on a reset edge.
  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    w_load_ok    = 1'b0;
    w_load       = 1'b0;

    w_fire    = w_valid && bus.out_enq__RDY && !RST;
    w_load_ok = !w_valid || (w_at_last && bus.out_enq__RDY);
    w_load    = bus.in_first__RDY && bus.in_deq__RDY && w_load_ok && !RST;

    // A load wins over the clear that would follow the last beat.
    if (w_load) begin
      w_state_next = ST_SENDING;
    end else if (w_fire && w_at_last) begin
      w_state_next = ST_EMPTY;
    end
  end

  // State register: EMPTY means no word held, SENDING means a word is held.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Beat index: restarts on every load, advances on every fired beat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx <= '0;
    end else if (w_load) begin
      r_idx <= '0;
    end else if (w_fire) begin
      r_idx <= w_at_last ? 5'd0 : r_idx + 5'd1;
    end
  end

  // Completed-word counter, free-running with natural 16-bit wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_words_sent <= '0;
    end else if (w_fire && w_at_last) begin
      r_words_sent <= r_words_sent + 16'd1;
    end
  end

  // Word buffer split into per-beat lanes; a shift moves every lane down by
  // one beat, and the top lane fills with zero.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      logic [BEAT_WIDTH-1:0] r_beat;
      logic [BEAT_WIDTH-1:0] w_shift_in;

      if (gi == BEATS - 1) begin : g_top
        assign w_shift_in = '0;
      end else begin : g_mid
        assign w_shift_in = w_buf_flat[(gi+1)*BEAT_WIDTH +: BEAT_WIDTH];
      end

      // Lane register: capture on load, shift on a non-final beat.
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_beat <= '0;
        end else if (w_load) begin
          r_beat <= bus.in_first[gi*BEAT_WIDTH +: BEAT_WIDTH];
        end else if (w_fire && !w_at_last) begin
          r_beat <= w_shift_in;
        end
      end

      assign w_buf_flat[gi*BEAT_WIDTH +: BEAT_WIDTH] = r_beat;
    end
  endgenerate

  assign bus.out_enq_v    = w_buf_flat[BEAT_WIDTH-1:0];
  assign bus.out_enq__ENA = w_fire;
  assign bus.out_last     = w_valid && w_at_last;
  assign bus.in_deq__ENA  = w_load;
  assign words_sent       = r_words_sent;

endmodule
